// File: rtl/stereo_frame_sched.sv
// Frame-level scheduler for the SGM stereo core: shadows the live config at frame start,
// validates it, starts the core and supervises completion with a cycle-budget timeout.
module stereo_frame_sched #(
  parameter int TMO_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_en,
  input  logic             frame_sof,
  input  logic [10:0]      cfg_width,
  input  logic [10:0]      cfg_height,
  input  logic [8:0]       cfg_range,
  input  logic             cfg_bypass,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             err_clr,
  input  logic             core_done,
  output logic             core_start,
  output logic             core_abort,
  output logic [10:0]      act_width,
  output logic [10:0]      act_height,
  output logic [8:0]       act_range,
  output logic             act_bypass,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic             err_cfg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_nxt;
  logic             cfg_ok;
  logic             sof_accept;
  logic             sof_overrun;
  logic             cfg_fail;
  logic             start_nxt;
  logic             done_evt;
  logic             tmo_evt;

  // Range is compared against width after zero-extension to the width's 11 bits.
  always_comb begin
    cfg_ok = (act_width  >= 11'd64) && (act_width  <= 11'd1920) &&
             (act_height >= 11'd16) && (act_height <= 11'd1080) &&
             (act_range != 9'd0) && (act_range[3:0] == 4'd0) &&
             ({2'b00, act_range} < act_width);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    sof_accept  = 1'b0;
    cfg_fail    = 1'b0;
    start_nxt   = 1'b0;
    done_evt    = 1'b0;
    tmo_evt     = 1'b0;
    sof_overrun = frame_sof && (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_sof && sched_en) begin
          sof_accept = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        if (cfg_ok) begin
          start_nxt = 1'b1;
          state_nxt = START;
        end else begin
          cfg_fail  = 1'b1;
          state_nxt = IDLE;
        end
      end
      START: begin
        tmo_cnt_nxt = '0;
        state_nxt   = RUN;
      end
      RUN: begin
        // Saturate so a disabled timeout never wraps back into a false match.
        if (tmo_cnt != {TMO_W{1'b1}}) begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
        if (core_done) begin
          done_evt  = 1'b1;
          state_nxt = IDLE;
        end else if ((tmo_limit != '0) && (tmo_cnt == (tmo_limit - TMO_W'(1)))) begin
          tmo_evt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_width   <= 11'd1920;
      act_height  <= 11'd1080;
      act_range   <= 9'd128;
      act_bypass  <= 1'b1;
      core_start  <= 1'b0;
      core_abort  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      if (sof_accept) begin
        act_width  <= cfg_width;
        act_height <= cfg_height;
        act_range  <= cfg_range;
        act_bypass <= cfg_bypass;
      end
      core_start <= start_nxt;
      core_abort <= tmo_evt;
      busy       <= (state_nxt != IDLE);
      if (done_evt) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      // A sof arriving in a failing LOAD cycle is a second, independent drop.
      drop_cnt    <= drop_cnt + CNT_W'(cfg_fail) + CNT_W'(sof_overrun);
      err_timeout <= (err_timeout & ~err_clr) | tmo_evt;
      err_overrun <= (err_overrun & ~err_clr) | sof_overrun;
      err_cfg     <= (err_cfg & ~err_clr) | cfg_fail;
    end
  end

endmodule

// File: tb/tb_stereo_frame_sched.sv
// Self-checking bench for stereo_frame_sched: directed scenarios then random traffic,
// every cycle compared against a frame-age based reference model.
module tb_stereo_frame_sched;

  logic        clk;
  logic        rst;
  logic        sched_en;
  logic        frame_sof;
  logic [10:0] cfg_width;
  logic [10:0] cfg_height;
  logic [8:0]  cfg_range;
  logic        cfg_bypass;
  logic [23:0] tmo_limit;
  logic        err_clr;
  logic        core_done;
  logic        core_start;
  logic        core_abort;
  logic [10:0] act_width;
  logic [10:0] act_height;
  logic [8:0]  act_range;
  logic        act_bypass;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_cfg;

  int checks = 0;
  int errors = 0;

  // Reference model: mAge is -1 when idle, else cycles elapsed since the frame was accepted.
  int mAge;
  int mW, mH, mR, mB;
  int mFrame, mDrop;
  int mErrT, mErrO, mErrC;
  int mStart, mAbort, mBusy;

  stereo_frame_sched #(.TMO_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .frame_sof(frame_sof),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_range(cfg_range),
    .cfg_bypass(cfg_bypass), .tmo_limit(tmo_limit), .err_clr(err_clr),
    .core_done(core_done), .core_start(core_start), .core_abort(core_abort),
    .act_width(act_width), .act_height(act_height), .act_range(act_range),
    .act_bypass(act_bypass), .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_cfg(err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit cfgValid(int w, int h, int r);
    return (w >= 64) && (w <= 1920) && (h >= 16) && (h <= 1080) &&
           (r != 0) && (r % 16 == 0) && (r < w);
  endfunction

  task automatic modelReset();
    mAge = -1;
    mW = 1920; mH = 1080; mR = 128; mB = 1;
    mFrame = 0; mDrop = 0;
    mErrT = 0; mErrO = 0; mErrC = 0;
    mStart = 0; mAbort = 0; mBusy = 0;
  endtask

  task automatic modelStep();
    int evT, evO, evC;
    evT = 0; evO = 0; evC = 0;
    mStart = 0;
    mAbort = 0;
    if (mAge < 0) begin
      if (frame_sof && sched_en) begin
        mW = cfg_width; mH = cfg_height; mR = cfg_range; mB = cfg_bypass;
        mAge = 0;
      end
    end else begin
      if (frame_sof) begin
        evO = 1;
        mDrop++;
      end
      if (mAge == 0) begin
        if (!cfgValid(mW, mH, mR)) begin
          evC = 1;
          mDrop++;
          mAge = -1;
        end else begin
          mStart = 1;
          mAge = 1;
        end
      end else if (mAge == 1) begin
        mAge = 2;
      end else if (core_done) begin
        mFrame = (mFrame + 1) & 16'hFFFF;
        mAge = -1;
      end else if ((tmo_limit != 0) && ((mAge - 2) == int'(tmo_limit) - 1)) begin
        evT = 1;
        mAbort = 1;
        mAge = -1;
      end else begin
        mAge++;
      end
    end
    mDrop = mDrop & 16'hFFFF;
    mErrT = (mErrT && !err_clr) || evT;
    mErrO = (mErrO && !err_clr) || evO;
    mErrC = (mErrC && !err_clr) || evC;
    mBusy = (mAge >= 0);
  endtask

  task automatic compareAll();
    checkOutput("core_start", core_start, mStart);
    checkOutput("core_abort", core_abort, mAbort);
    checkOutput("act_width", act_width, mW);
    checkOutput("act_height", act_height, mH);
    checkOutput("act_range", act_range, mR);
    checkOutput("act_bypass", act_bypass, mB);
    checkOutput("busy", busy, mBusy);
    checkOutput("frame_cnt", frame_cnt, mFrame);
    checkOutput("drop_cnt", drop_cnt, mDrop);
    checkOutput("err_timeout", err_timeout, mErrT);
    checkOutput("err_overrun", err_overrun, mErrO);
    checkOutput("err_cfg", err_cfg, mErrC);
  endtask

  // Inputs are already driven; advance one clock and compare against the model.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
    frame_sof = 1'b0;
    err_clr   = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic setCfg(input int w, input int h, input int r, input int b);
    cfg_width  = 11'(w);
    cfg_height = 11'(h);
    cfg_range  = 9'(r);
    cfg_bypass = b[0];
  endtask

  initial begin
    int n;
    rst = 1'b1;
    sched_en = 1'b1; frame_sof = 1'b0; err_clr = 1'b0; core_done = 1'b0;
    tmo_limit = 24'd0;
    setCfg(640, 480, 64, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    rst = 1'b0;

    // Basic frame with done 100 cycles after start.
    frame_sof = 1'b1;
    applyStimulus();
    checkOutput("commit_width", act_width, 640);
    checkOutput("no_early_start", core_start, 0);
    applyStimulus();
    checkOutput("start_latency", core_start, 1);
    repeat (99) applyStimulus();
    core_done = 1'b1;
    applyStimulus();
    checkOutput("frame_after_done", frame_cnt, 1);
    checkOutput("idle_after_done", busy, 0);

    // Live width change during RUN is deferred to the next accepted sof.
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    cfg_width = 11'd320;
    repeat (5) applyStimulus();
    checkOutput("shadow_hold", act_width, 640);
    core_done = 1'b1;
    applyStimulus();
    frame_sof = 1'b1;
    applyStimulus();
    checkOutput("shadow_update", act_width, 320);
    applyStimulus();
    applyStimulus();
    core_done = 1'b1;
    applyStimulus();

    // Timeout with a 50 cycle budget.
    tmo_limit = 24'd50;
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      applyStimulus();
      if (core_abort) begin
        n = i;
        break;
      end
    end
    checkOutput("abort_delay", n, 51);
    checkOutput("timeout_flag", err_timeout, 1);
    checkOutput("timeout_frames", frame_cnt, 3);
    err_clr = 1'b1;
    applyStimulus();
    checkOutput("timeout_cleared", err_timeout, 0);
    tmo_limit = 24'd0;

    // Overrun: second sof ten cycles into RUN.
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    repeat (10) applyStimulus();
    cfg_width = 11'd800;
    frame_sof = 1'b1;
    applyStimulus();
    checkOutput("overrun_flag", err_overrun, 1);
    checkOutput("overrun_drop", drop_cnt, 1);
    checkOutput("overrun_shadow", act_width, 320);
    core_done = 1'b1;
    applyStimulus();
    checkOutput("overrun_frames", frame_cnt, 4);

    // Config errors: range not multiple of 16, then range not below width.
    setCfg(320, 240, 72, 0);
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("cfg_err_flag", err_cfg, 1);
    checkOutput("cfg_err_nostart", core_start, 0);
    checkOutput("cfg_err_drop", drop_cnt, 2);
    setCfg(320, 240, 400, 1);
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("cfg_err_drop2", drop_cnt, 3);
    setCfg(320, 240, 64, 1);
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("cfg_recover_start", core_start, 1);
    applyStimulus();
    core_done = 1'b1;
    applyStimulus();

    // Done in the same cycle as the timeout match.
    err_clr = 1'b1;
    applyStimulus();
    tmo_limit = 24'd20;
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    repeat (20) applyStimulus();
    core_done = 1'b1;
    applyStimulus();
    checkOutput("tie_frames", frame_cnt, 6);
    checkOutput("tie_no_timeout", err_timeout, 0);
    checkOutput("tie_no_abort", core_abort, 0);
    tmo_limit = 24'd0;

    // Asynchronous reset in the middle of RUN.
    frame_sof = 1'b1;
    applyStimulus();
    applyStimulus();
    repeat (5) applyStimulus();
    rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    checkOutput("reset_no_abort", core_abort, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        tmo_limit = ($urandom_range(0, 2) == 0) ? 24'd0 : 24'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 49) == 0) sched_en = ~sched_en;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          setCfg($urandom_range(0, 2047), $urandom_range(0, 2047),
                 $urandom_range(0, 511), $urandom_range(0, 1));
        end else begin
          setCfg($urandom_range(520, 1920), $urandom_range(16, 1080),
                 16 * $urandom_range(1, 31), $urandom_range(0, 1));
        end
      end
      frame_sof = ($urandom_range(0, 24) == 0);
      core_done = ($urandom_range(0, 29) == 0);
      err_clr   = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
